// File: rtl/base_pipeline.sv
// Five-stage in-order RV32I-subset core (IF, ID, EX, MEM, WB) with its own instruction ROM,
// register file and data RAM. Forwarding into EX and a one-cycle load-use stall resolve hazards.

module instruction_rom_wrapper (
    input  logic        clk,
    input  logic [31:0] addr,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] dout
);
    logic [31:0] data [0:4095];
    logic        unused_addr;

    assign unused_addr = ^{addr[31:14], addr[1:0]};

    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (en) begin
            dout <= data[addr[13:2]];
        end
    end
endmodule

module register_file (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);
    logic [31:0] data [31:0];

    // NOTE: storage has no reset so preloaded register values survive rst.
    always_ff @(posedge clk_i) begin
        if (we_i && waddr_i != 5'd0) begin
            data[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0)                 ? '0      :
                      (we_i && waddr_i == raddr1_i)      ? wdata_i : data[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0)                 ? '0      :
                      (we_i && waddr_i == raddr2_i)      ? wdata_i : data[raddr2_i];
endmodule

module ram_wrapper (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [11:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    logic [31:0] data [0:4095];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            data[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = data[addr_i];
endmodule

module ram_port (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    logic unused_addr;

    assign unused_addr = ^{addr_i[31:14], addr_i[1:0]};

    ram_wrapper ram_wrapper0 (
        .clk_i   (clk_i),
        .we_i    (we_i),
        .addr_i  (addr_i[13:2]),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o)
    );
endmodule

module base_pipeline (
    input  logic clk,
    input  logic rst
);
    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        alu_op_e     alu_op;
        logic        use_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        branch_ne;
        logic        jal;
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_wb_t;

    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic sub, input logic arith);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = sub ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = arith ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] instr;
    logic        rom_en;
    logic        use_rs1, use_rs2;
    logic        load_use, stall, flush;
    logic [31:0] branch_target;
    logic [31:0] rf_rdata1, rf_rdata2, ram_rdata;
    logic        rf_we;
    logic [31:0] op_a, fwd_b, op_b, alu_y;
    id_ex_t      dec, id_ex_d, id_ex_q;
    ex_mem_t     ex_mem_d, ex_mem_q;
    mem_wb_t     mem_wb_d, mem_wb_q;

    assign rom_en = !stall;

    instruction_rom_wrapper instruction_rom0 (
        .clk  (clk),
        .addr (pc_q),
        .rst  (rst),
        .en   (rom_en),
        .dout (instr)
    );

    always_comb begin
        // NOTE: every output gets a default first so no decode path infers a latch.
        dec        = '0;
        dec.alu_op = ALU_ADD;
        dec.pc     = if_pc_q;
        dec.rd     = instr[11:7];
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        if (if_valid_q) begin
            dec.valid = 1'b1;
            case (instr[6:0])
                OPC_REG: begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = alu_decode(instr[14:12], instr[30], instr[30]);
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                end
                OPC_IMM: begin
                    dec.reg_write = 1'b1;
                    dec.use_imm   = 1'b1;
                    dec.imm       = {{20{instr[31]}}, instr[31:20]};
                    dec.alu_op    = alu_decode(instr[14:12], 1'b0, instr[30]);
                    use_rs1       = 1'b1;
                end
                OPC_LUI: begin
                    dec.reg_write = 1'b1;
                    dec.use_imm   = 1'b1;
                    dec.imm       = {instr[31:12], 12'b0};
                end
                OPC_LOAD: begin
                    if (instr[14:12] == 3'b010) begin
                        dec.reg_write = 1'b1;
                        dec.mem_read  = 1'b1;
                        dec.use_imm   = 1'b1;
                        dec.imm       = {{20{instr[31]}}, instr[31:20]};
                        use_rs1       = 1'b1;
                    end
                end
                OPC_STORE: begin
                    if (instr[14:12] == 3'b010) begin
                        dec.mem_write = 1'b1;
                        dec.use_imm   = 1'b1;
                        dec.imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                        use_rs1       = 1'b1;
                        use_rs2       = 1'b1;
                    end
                end
                OPC_BRANCH: begin
                    if (instr[14:13] == 2'b00) begin
                        dec.branch    = 1'b1;
                        dec.branch_ne = instr[12];
                        dec.imm       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                        use_rs1       = 1'b1;
                        use_rs2       = 1'b1;
                    end
                end
                OPC_JAL: begin
                    dec.reg_write = 1'b1;
                    dec.jal       = 1'b1;
                    dec.imm       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                end
                default: ;
            endcase
        end
        dec.rs1 = use_rs1 ? instr[19:15] : 5'd0;
        dec.rs2 = use_rs2 ? instr[24:20] : 5'd0;
    end

    register_file register_file0 (
        .clk_i    (clk),
        .we_i     (rf_we),
        .waddr_i  (mem_wb_q.rd),
        .wdata_i  (mem_wb_q.data),
        .raddr1_i (dec.rs1),
        .raddr2_i (dec.rs2),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    // Unused source fields are zeroed in decode, so x0 never matches a load destination.
    assign load_use = id_ex_q.valid && id_ex_q.mem_read && id_ex_q.rd != 5'd0 &&
                      (dec.rs1 == id_ex_q.rd || dec.rs2 == id_ex_q.rd);
    assign stall    = load_use && !flush;

    always_comb begin
        id_ex_d         = dec;
        id_ex_d.rs1_val = rf_rdata1;
        id_ex_d.rs2_val = rf_rdata2;
        if (flush || stall) begin
            id_ex_d = '0;
        end
    end

    always_comb begin
        op_a = id_ex_q.rs1_val;
        if (ex_mem_q.reg_write && !ex_mem_q.mem_read && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs1) begin
            op_a = ex_mem_q.result;
        end else if (mem_wb_q.reg_write && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs1) begin
            op_a = mem_wb_q.data;
        end
        fwd_b = id_ex_q.rs2_val;
        if (ex_mem_q.reg_write && !ex_mem_q.mem_read && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs2) begin
            fwd_b = ex_mem_q.result;
        end else if (mem_wb_q.reg_write && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs2) begin
            fwd_b = mem_wb_q.data;
        end
    end

    assign op_b = id_ex_q.use_imm ? id_ex_q.imm : fwd_b;

    always_comb begin
        case (id_ex_q.alu_op)
            ALU_SUB:  alu_y = op_a - op_b;
            ALU_AND:  alu_y = op_a & op_b;
            ALU_OR:   alu_y = op_a | op_b;
            ALU_XOR:  alu_y = op_a ^ op_b;
            ALU_SLL:  alu_y = op_a << op_b[4:0];
            ALU_SRL:  alu_y = op_a >> op_b[4:0];
            ALU_SRA:  alu_y = 32'($signed(op_a) >>> op_b[4:0]);
            ALU_SLT:  alu_y = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_y = {31'b0, op_a < op_b};
            default:  alu_y = op_a + op_b;
        endcase
    end

    assign branch_target = id_ex_q.pc + id_ex_q.imm;
    assign flush = id_ex_q.valid &&
                   (id_ex_q.jal || (id_ex_q.branch && ((op_a == fwd_b) != id_ex_q.branch_ne)));

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.valid      = id_ex_q.valid;
        ex_mem_d.result     = id_ex_q.jal ? id_ex_q.pc + 32'd4 : alu_y;
        ex_mem_d.store_data = fwd_b;
        ex_mem_d.rd         = id_ex_q.rd;
        ex_mem_d.reg_write  = id_ex_q.valid && id_ex_q.reg_write;
        ex_mem_d.mem_read   = id_ex_q.valid && id_ex_q.mem_read;
        ex_mem_d.mem_write  = id_ex_q.valid && id_ex_q.mem_write;
    end

    ram_port ram_port0 (
        .clk_i   (clk),
        .we_i    (ex_mem_q.mem_write),
        .addr_i  (ex_mem_q.result),
        .wdata_i (ex_mem_q.store_data),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        mem_wb_d.valid     = ex_mem_q.valid;
        mem_wb_d.data      = ex_mem_q.mem_read ? ram_rdata : ex_mem_q.result;
        mem_wb_d.rd        = ex_mem_q.rd;
        mem_wb_d.reg_write = ex_mem_q.reg_write;
    end

    assign rf_we = mem_wb_q.valid && mem_wb_q.reg_write && mem_wb_q.rd != 5'd0;

    // The instruction arriving from the ROM behind a taken branch/JAL is marked invalid.
    always_comb begin
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        if (flush) begin
            pc_d       = branch_target;
            if_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d       = pc_q + 32'd4;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
            id_ex_q    <= '0;
            ex_mem_q   <= '0;
            mem_wb_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            id_ex_q    <= id_ex_d;
            ex_mem_q   <= ex_mem_d;
            mem_wb_q   <= mem_wb_d;
        end
    end
endmodule

// File: tb/tb_base_pipeline.sv
// Directed programs for base_pipeline; expected architectural state is queued per program
// and compared against the register file and data RAM once the program has run.

module tb_base_pipeline;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    base_pipeline dut (
        .clk (clk),
        .rst (rst)
    );

    typedef struct {
        string       tag;
        logic        is_ram;
        int          idx;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   prog_len = 0;

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 0, rd, 7'b0010011);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_reg(input string tag, input int idx, input logic [31:0] value);
        exp_t e;
        e.tag = tag; e.is_ram = 1'b0; e.idx = idx; e.value = value;
        sb.push_back(e);
    endtask

    task automatic expect_ram(input string tag, input int idx, input logic [31:0] value);
        exp_t e;
        e.tag = tag; e.is_ram = 1'b1; e.idx = idx; e.value = value;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = e.is_ram ? dut.ram_port0.ram_wrapper0.data[e.idx] : dut.register_file0.data[e.idx];
            check(e.tag, obs, e.value);
        end
    endtask

    // Hold reset, blank the ROM, preload xi=i (i<=10) and RAM word i = 10*i.
    task automatic begin_test();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4096; i++) dut.instruction_rom0.data[i] <= '0;
        for (int i = 0; i < 32; i++) dut.register_file0.data[i] <= (i <= 10) ? 32'(i) : 32'd0;
        for (int i = 0; i < 16; i++) dut.ram_port0.ram_wrapper0.data[i] <= 32'(10 * i);
        prog_len = 0;
    endtask

    task automatic emit(input logic [31:0] w);
        dut.instruction_rom0.data[prog_len] <= w;
        prog_len++;
    endtask

    task automatic run(input int cycles);
        @(negedge clk);
        rst = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        // Mixed forwarding with a load-use stall; three instructions must finish within 10 cycles.
        begin_test();
        check("reset_pc", dut.pc_q, 32'd0);
        check("reset_rom_dout", dut.instruction_rom0.dout, 32'd0);
        check("reset_valid_bits",
              {29'd0, dut.if_valid_q, dut.id_ex_q.valid, dut.ex_mem_q.valid | dut.mem_wb_q.valid}, 32'd0);
        emit(addi(1, 0, 20));
        emit(enc_i(4, 0, 3'b010, 2, 7'b0000011));
        emit(enc_r(0, 2, 1, 0, 3));
        expect_reg("mixed_x1", 1, 32'd20);
        expect_reg("mixed_x2", 2, 32'd10);
        expect_reg("mixed_x3", 3, 32'd30);
        run(10);
        drain();

        // Back-to-back ALU dependencies through EX/MEM and MEM/WB.
        begin_test();
        emit(addi(1, 0, 5));
        emit(enc_r(0, 1, 1, 0, 2));
        emit(enc_r(7'b0100000, 1, 2, 0, 3));
        expect_reg("chain_x2", 2, 32'd10);
        expect_reg("chain_x3", 3, 32'd5);
        run(20);
        drain();

        // Store then load of the same word.
        begin_test();
        emit(addi(1, 0, 77));
        emit(enc_s(8, 1, 0));
        emit(enc_i(8, 0, 3'b010, 4, 7'b0000011));
        expect_ram("store_ram2", 2, 32'd77);
        expect_reg("load_x4", 4, 32'd77);
        run(20);
        drain();

        // Taken BEQ flushes the two younger instructions.
        begin_test();
        emit(addi(1, 0, 1));
        emit(enc_b(12, 1, 1, 3'b000));
        emit(addi(5, 0, 9));
        emit(addi(6, 0, 9));
        emit(addi(7, 0, 3));
        expect_reg("flush_x5", 5, 32'd5);
        expect_reg("flush_x6", 6, 32'd6);
        expect_reg("branch_x7", 7, 32'd3);
        run(20);
        drain();

        // x0 is hard-wired to zero.
        begin_test();
        emit(addi(0, 0, 5));
        emit(enc_r(0, 0, 0, 0, 8));
        expect_reg("x0_kept_zero", 0, 32'd0);
        expect_reg("x8_from_x0", 8, 32'd0);
        run(20);
        drain();

        // Shifts, compares, JAL and BNE.
        begin_test();
        emit({20'h80000, 5'd1, 7'b0110111});
        emit(enc_i(12'h404, 1, 3'b101, 2, 7'b0010011));
        emit(enc_i(12'h004, 1, 3'b101, 3, 7'b0010011));
        emit(enc_r(0, 0, 1, 3'b010, 4));
        emit(enc_r(0, 0, 1, 3'b011, 5));
        emit(enc_r(0, 3, 2, 3'b100, 6));
        emit(enc_j(8, 7));
        emit(addi(9, 0, 99));
        emit(enc_b(8, 3, 2, 3'b001));
        emit(addi(10, 0, 99));
        emit(enc_r(0, 4, 3, 3'b110, 11));
        expect_reg("lui_x1", 1, 32'h8000_0000);
        expect_reg("srai_x2", 2, 32'hF800_0000);
        expect_reg("srli_x3", 3, 32'h0800_0000);
        expect_reg("slt_x4", 4, 32'd1);
        expect_reg("sltu_x5", 5, 32'd0);
        expect_reg("xor_x6", 6, 32'hF000_0000);
        expect_reg("jal_link_x7", 7, 32'd28);
        expect_reg("jal_skip_x9", 9, 32'd9);
        expect_reg("bne_skip_x10", 10, 32'd10);
        expect_reg("or_x11", 11, 32'h0800_0001);
        run(40);
        drain();

        // Asynchronous reset mid-program: nothing in flight may write, then a clean re-run.
        begin_test();
        emit(addi(2, 0, 70));
        emit(addi(3, 0, 71));
        emit(addi(4, 0, 72));
        run(3);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_pc_async", dut.pc_q, 32'd0);
        check("midrst_if_valid", {31'd0, dut.if_valid_q}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("midrst_rom_dout", dut.instruction_rom0.dout, 32'd0);
        expect_reg("midrst_no_write_x2", 2, 32'd2);
        expect_reg("midrst_no_write_x3", 3, 32'd3);
        expect_reg("midrst_no_write_x4", 4, 32'd4);
        drain();
        expect_reg("rerun_x2", 2, 32'd70);
        expect_reg("rerun_x3", 3, 32'd71);
        expect_reg("rerun_x4", 4, 32'd72);
        run(20);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
